// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, IVs, round constants and sigma helpers.
package sha256_pkg;

    typedef logic [31:0] word_t;
    // Index 7 holds a / H0, index 0 holds h / H7, so {hash} reads H0 first.
    typedef word_t [7:0] hash_t;
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam hash_t IV_256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam hash_t IV_224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t bsig0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t bsig1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t cur,
    input  word_t k,
    input  word_t w,
    output hash_t nxt
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1  = cur[0] + bsig1(cur[3]) + ((cur[3] & cur[2]) ^ (~cur[3] & cur[1])) + k + w;
        t2  = bsig0(cur[7]) + ((cur[7] & cur[6]) ^ (cur[7] & cur[5]) ^ (cur[6] & cur[5]));
        nxt = {t1 + t2, cur[7], cur[6], cur[5], cur[4] + t1, cur[3], cur[2], cur[1]};
    end

endmodule

// File: rtl/hash_engine_multi.sv
// Multi-round-per-cycle SHA-256 block engine with chaining and digest handshake.
// Define HASH_ENGINE_SHA224_EN to add the mode_224 input for SHA-224 support.
module hash_engine_multi
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
`ifdef HASH_ENGINE_SHA224_EN
    ,
    input  logic         mode_224
`endif
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [6:0] STEP     = 7'(R);
    localparam logic [6:0] LAST_IDX = 7'(64 - R);

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    state_t     state;
    hash_t      chain;
    hash_t      work;
    word_t      w [0:15];
    logic [6:0] idx;
    logic       last_q;

    word_t ext   [0:15+R];
    word_t kv    [0:R-1];
    hash_t stage [0:R];
    hash_t sum;
    hash_t iv_sel;
    hash_t final_digest;

`ifdef HASH_ENGINE_SHA224_EN
    logic mode_q;
    assign iv_sel = mode_224 ? IV_224 : IV_256;
`else
    assign iv_sel = IV_256;
`endif

    // Extend the 16-word window by R words so each chained round has its W.
    always_comb begin
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < R; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        for (int j = 0; j < R; j++) kv[j] = K[6'(idx + 7'(j))];
    end

    assign stage[0] = work;

    generate
        for (genvar j = 0; j < R; j++) begin : g_round
            sha256_round u_round (
                .cur (stage[j]),
                .k   (kv[j]),
                .w   (ext[j]),
                .nxt (stage[j+1])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 8; i++) sum[i] = chain[i] + work[i];
        final_digest = sum;
`ifdef HASH_ENGINE_SHA224_EN
        if (mode_q) final_digest[0] = '0;
`endif
    end

    assign blk_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            chain        <= IV_256;
            work         <= '0;
            idx          <= '0;
            last_q       <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
`ifdef HASH_ENGINE_SHA224_EN
            mode_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (blk_valid) begin
                    for (int i = 0; i < 16; i++) w[i] <= blk_data[511-32*i -: 32];
                    last_q <= blk_last;
                    idx    <= '0;
                    if (blk_first) begin
                        chain <= iv_sel;
                        work  <= iv_sel;
`ifdef HASH_ENGINE_SHA224_EN
                        mode_q <= mode_224;
`endif
                    end else begin
                        work <= chain;
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    work <= stage[R];
                    for (int i = 0; i < 16; i++) w[i] <= ext[i+R];
                    idx <= idx + STEP;
                    if (idx == LAST_IDX) state <= FINAL;
                end
                FINAL: begin
                    chain <= sum;
                    if (last_q) begin
                        state        <= DONE;
                        digest_valid <= 1'b1;
                        digest       <= final_digest;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: if (digest_ready) begin
                    state        <= IDLE;
                    digest_valid <= 1'b0;
                    digest       <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_engine_multi.sv
// Scoreboard bench: R=1 and R=8 engines fed identical blocks, known SHA-256 vectors.
module tb_hash_engine_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, blk_valid, blk_first, blk_last, digest_ready;
    logic [511:0] blk_data;
    logic         rdy1, dv1, rdy8, dv8;
    logic [255:0] dg1, dg8;
`ifdef HASH_ENGINE_SHA224_EN
    logic         mode_224 = 1'b0;
`endif

    hash_engine_multi #(.ROUNDS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(rdy1), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .digest_valid(dv1),
        .digest_ready(digest_ready), .digest(dg1)
`ifdef HASH_ENGINE_SHA224_EN
        , .mode_224(mode_224)
`endif
    );

    hash_engine_multi #(.ROUNDS_PER_CYCLE(8)) u8 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(rdy8), .blk_data(blk_data),
        .blk_first(blk_first), .blk_last(blk_last), .digest_valid(dv8),
        .digest_ready(digest_ready), .digest(dg8)
`ifdef HASH_ENGINE_SHA224_EN
        , .mode_224(mode_224)
`endif
    );

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0;
    logic [255:0] q1 [$];
    logic [255:0] q8 [$];
    logic pv1 = 1'b0, pv8 = 1'b0;

    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;
    logic [255:0] dig_abc, dig_empty, dig_two, dig_224;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the R=1 engine
    always @(negedge clk) begin
        if (!rst) begin
            if (dv1 && !pv1) begin
                checks++;
                if (cyc - acc_cyc != 65) begin
                    errors++;
                    $display("FAIL lat_r1 got %0d want 65", cyc - acc_cyc);
                end
            end
            checks++;
            if (!dv1 && dg1 !== '0) begin
                errors++;
                $display("FAIL idle_digest_r1 got %h want 0", dg1);
            end
            if (dv1 && digest_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_r1 got %h want none", dg1);
                end else begin
                    logic [255:0] e;
                    e = q1.pop_front();
                    if (dg1 !== e) begin
                        errors++;
                        $display("FAIL digest_r1 got %h want %h", dg1, e);
                    end
                end
            end
        end
        pv1 = dv1;
    end

    // Monitor for the R=8 engine
    always @(negedge clk) begin
        if (!rst) begin
            if (dv8 && !pv8) begin
                checks++;
                if (cyc - acc_cyc != 9) begin
                    errors++;
                    $display("FAIL lat_r8 got %0d want 9", cyc - acc_cyc);
                end
            end
            checks++;
            if (!dv8 && dg8 !== '0) begin
                errors++;
                $display("FAIL idle_digest_r8 got %h want 0", dg8);
            end
            if (dv8 && digest_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_r8 got %h want none", dg8);
                end else begin
                    logic [255:0] e;
                    e = q8.pop_front();
                    if (dg8 !== e) begin
                        errors++;
                        $display("FAIL digest_r8 got %h want %h", dg8, e);
                    end
                end
            end
        end
        pv8 = dv8;
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!(rdy1 && rdy8) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("ready_timeout", {255'd0, rdy1 && rdy8}, 256'd1);
    endtask

    task automatic send(input logic [511:0] d, input logic f, input logic l);
        wait_ready();
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        blk_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        blk_valid = 1'b0;
        blk_data  = {16{$urandom()}};
        blk_first = 1'($urandom());
        blk_last  = 1'($urandom());
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q8.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 256'(q1.size() + q8.size()), 256'd0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_rdy1"}, {255'd0, rdy1}, 256'd1);
        chk({name, "_rdy8"}, {255'd0, rdy8}, 256'd1);
        chk({name, "_dv1"},  {255'd0, dv1},  256'd0);
        chk({name, "_dv8"},  {255'd0, dv8},  256'd0);
        chk({name, "_dg1"},  dg1, 256'd0);
        chk({name, "_dg8"},  dg8, 256'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_abc   = {32'h61626380, {14{32'h0}}, 32'h00000018};
        blk_empty = {32'h80000000, {15{32'h0}}};
        blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two2  = {{15{32'h0}}, 32'h000001c0};
        dig_abc   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        dig_empty = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
        dig_two   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
        dig_224   = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;

        rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
        blk_data = '0; digest_ready = 1'b1;
        @(negedge clk);
        chk_idle("in_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        // Single-block "abc" and empty message
        q1.push_back(dig_abc);   q8.push_back(dig_abc);
        send(blk_abc, 1'b1, 1'b1);
        drain();
        q1.push_back(dig_empty); q8.push_back(dig_empty);
        send(blk_empty, 1'b1, 1'b1);
        drain();

        // Two-block message with a 3-cycle gap between blocks
        q1.push_back(dig_two);   q8.push_back(dig_two);
        send(blk_two1, 1'b1, 1'b0);
        wait_ready();
        repeat (3) @(negedge clk);
        send(blk_two2, 1'b0, 1'b1);
        drain();

        // Hold the digest in DONE for 10 cycles
        @(posedge clk); #1 digest_ready = 1'b0;
        q1.push_back(dig_abc);   q8.push_back(dig_abc);
        send(blk_abc, 1'b1, 1'b1);
        begin
            int n = 0;
            while (!dv1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_dv1",  {255'd0, dv1},  256'd1);
            chk("stall_dg1",  dg1, dig_abc);
            chk("stall_dg8",  dg8, dig_abc);
            chk("stall_rdy1", {255'd0, rdy1}, 256'd0);
            chk("stall_rdy8", {255'd0, rdy8}, 256'd0);
        end
        @(posedge clk); #1 digest_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_rdy1", {255'd0, rdy1}, 256'd1);
        chk("release_rdy8", {255'd0, rdy8}, 256'd1);
        drain();

        // Reset mid-message on the R=1 engine; R=8 finishes before reset
        q8.push_back(dig_abc);
        send(blk_abc, 1'b1, 1'b1);
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset");
        chk("mid_reset_q8", 256'(q8.size()), 256'd0);
        q1.push_back(dig_abc);   q8.push_back(dig_abc);
        send(blk_abc, 1'b1, 1'b1);
        drain();

`ifdef HASH_ENGINE_SHA224_EN
        mode_224 = 1'b1;
        q1.push_back(dig_224);   q8.push_back(dig_224);
        send(blk_abc, 1'b1, 1'b1);
        mode_224 = 1'b0;
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_engine_multi.md
HASH_ENGINE_MULTI -- requirements
Module: hash_engine_multi

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, compression rounds per clock; legal values 1, 2, 4, 8; any other value fails elaboration.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port blk_valid  input  1  a 512-bit message block is offered.
REQ-005 SHALL have port blk_ready  output  1  engine can accept a block.
REQ-006 SHALL have port blk_data  input  512  padded block; word 0 in bits [511:480].
REQ-007 SHALL have port blk_first  input  1  block starts a message; chaining value is loaded with the IV.
REQ-008 SHALL have port blk_last  input  1  block ends a message; digest is produced after it.
REQ-009 SHALL have port digest_valid  output  1  digest holds a final hash.
REQ-010 SHALL have port digest_ready  input  1  consumer accepts the digest.
REQ-011 SHALL have port digest  output  256  H0 in bits [255:224].

Function
REQ-012 SHALL use a four-state FSM: IDLE, ROUND, FINAL, DONE.
REQ-013 blk_ready SHALL be 1 only in IDLE; a block is accepted when blk_valid and blk_ready are both high at a rising edge.
REQ-014 On acceptance, the engine SHALL capture blk_data, blk_first and blk_last, load the working variables a..h from the chaining value (the IV if blk_first is set), and enter ROUND.
REQ-015 ROUND SHALL last exactly 64/ROUNDS_PER_CYCLE cycles, with a 7-bit round index advancing by ROUNDS_PER_CYCLE each cycle; schedule words W16..W63 SHALL come from a 16-word shifting window.
REQ-016 FINAL SHALL last one cycle and add a..h to the chaining value, mod 2^32 per word.
REQ-017 After FINAL, the engine SHALL enter DONE if blk_last was set, otherwise IDLE.
REQ-018 digest_valid SHALL rise exactly 64/ROUNDS_PER_CYCLE+1 cycles after the accepting edge (65 cycles for R=1, 9 cycles for R=8).
REQ-019 In DONE, digest_valid and digest SHALL be held stable until digest_ready is high; on that edge the engine SHALL return to IDLE.
REQ-020 digest SHALL read 0 whenever digest_valid is 0.
REQ-021 A block accepted without blk_first SHALL chain from the current chaining value, including after a completed message.
REQ-022 A block with both blk_first and blk_last SHALL be treated as a single-block message.
REQ-023 blk_data, blk_first and blk_last SHALL be ignored outside the accepting edge.

Reset
REQ-024 rst high at a rising edge SHALL force IDLE and load the chaining value with the SHA-256 IV; it SHALL discard any block in progress.
REQ-025 Output values SHALL be blk_ready=1, digest_valid=0 and digest=0 during reset and in the first cycle after reset.
REQ-026 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-027 The macro HASH_ENGINE_SHA224_EN SHALL control SHA-224 support.
REQ-028 When HASH_ENGINE_SHA224_EN is defined: an input port mode_224 (1 bit) SHALL exist; it SHALL be sampled on a blk_first acceptance; if set, the SHA-224 IV SHALL be used and digest[31:0] SHALL be forced to 0 in DONE.
REQ-029 When HASH_ENGINE_SHA224_EN is undefined: mode_224 SHALL be absent and behaviour SHALL be SHA-256 only.

Structure
REQ-030 A shared package sha256_pkg SHALL hold the K[0:63] constant table, IV_256, IV_224, the word_t (32-bit) typedef, the hash_t (8 x word_t) typedef and the FSM state enum.
REQ-031 There SHALL be one sub-module, sha256_round: one combinational round (a..h, K, W in; a..h out), instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-032 Message "abc", single block, R=1 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with digest_valid rising 65 cycles after acceptance.
REQ-033 Empty message, R=8 -> digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, with digest_valid rising 9 cycles after acceptance.
REQ-034 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last), with blk_valid gapped 3 cycles between blocks -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
REQ-035 SHA-224 build, mode_224=1, message "abc" -> digest 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.
REQ-036 Assert rst at round 30, then send "abc" -> blk_ready=1 and digest_valid=0 after reset, and a correct "abc" digest.
REQ-037 Hold digest_ready=0 for 10 cycles in DONE -> digest stable and blk_ready=0 throughout; one cycle of digest_ready -> IDLE.
